// File: rtl/carry_select.sv
// Registered carry-select adder: {cout, sum} <= a + b + carry, one cycle latency.
// Block 0 ripples from carry-in; every higher block precomputes both carry cases and muxes.
module carry_select #(
    parameter int WIDTH = 4,
    parameter int BLK   = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic             clk,
    input  logic             rst_n
);

    localparam int SAFE_BLK = (BLK > 0) ? BLK : 1;
    localparam int NBLK     = (WIDTH / SAFE_BLK > 0) ? WIDTH / SAFE_BLK : 1;

    if ((BLK < 1) || (BLK > WIDTH) || ((WIDTH % SAFE_BLK) != 0)) begin : g_param_check
        $error("carry_select: BLK must satisfy 1 <= BLK <= WIDTH and divide WIDTH");
    end

    // Ripple chain of BLK full adders; result is {block carry, sum bits}.
    function automatic logic [BLK:0] ripple(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           ci
    );
        logic [BLK:0]   c;
        logic [BLK-1:0] s;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < BLK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[BLK], s};
    endfunction

    logic [WIDTH-1:0] s;
    logic             c_out;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        logic [BLK-1:0] x;
        logic [BLK-1:0] y;
        logic [BLK-1:0] sb;
        logic           co;

        assign x = a[k*BLK +: BLK];
        assign y = b[k*BLK +: BLK];

        if (k == 0) begin : g_ripple
            assign {co, sb} = ripple(x, y, carry);
        end else begin : g_select
            logic [BLK:0] res0;
            logic [BLK:0] res1;
            logic         ci;

            // The block carry only drives the mux select, so each block adds one mux delay.
            assign ci       = g_blk[k-1].co;
            assign res0     = ripple(x, y, 1'b0);
            assign res1     = ripple(x, y, 1'b1);
            assign {co, sb} = ci ? res1 : res0;
        end

        assign s[k*BLK +: BLK] = sb;
    end

    assign c_out = g_blk[NBLK-1].co;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c_out;
        end
    end

endmodule

// File: tb/tb_carry_select.sv
// Directed and exhaustive checks of carry_select at WIDTH=4/BLK=2,
// plus a random run on a WIDTH=16/BLK=4 instance against a behavioural sum.
module tb_carry_select;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a, b, sum;
    logic        carry, cout;
    logic [15:0] a16, b16, sum16;
    logic        carry16, cout16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    carry_select #(.WIDTH(4), .BLK(2)) dut (
        .a(a), .b(b), .carry(carry), .sum(sum), .cout(cout),
        .clk(clk), .rst_n(rst_n)
    );

    carry_select #(.WIDTH(16), .BLK(4)) dut16 (
        .a(a16), .b(b16), .carry(carry16), .sum(sum16), .cout(cout16),
        .clk(clk), .rst_n(rst_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic [3:0] va, input logic [3:0] vb, input logic vc, input logic vr);
        @(negedge clk);
        a = va; b = vb; carry = vc; rst_n = vr;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic       vc;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        // {cout, sum} values computed by hand.
        vecs[0] = '{4'b0110, 4'b1010, 1'b1, 5'b1_0001};
        vecs[1] = '{4'b0000, 4'b1111, 1'b1, 5'b1_0000};
        vecs[2] = '{4'b1110, 4'b0000, 1'b0, 5'b0_1110};
        vecs[3] = '{4'b0001, 4'b0101, 1'b1, 5'b0_0111};
        vecs[4] = '{4'b0110, 4'b0110, 1'b1, 5'b0_1101};
        vecs[5] = '{4'b0111, 4'b1100, 1'b1, 5'b1_0100};
        vecs[6] = '{4'b1111, 4'b1000, 1'b0, 5'b1_0111};

        a = '0; b = '0; carry = 1'b0; rst_n = 1'b0;
        a16 = '0; b16 = '0; carry16 = 1'b0;

        // Reset held for two edges with all-ones inputs.
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        check("reset_edge1", {27'd0, cout, sum}, 32'h0);
        step(4'b1111, 4'b1111, 1'b1, 1'b0);
        check("reset_edge2", {27'd0, cout, sum}, 32'h0);
        check("reset_w16", {15'd0, cout16, sum16}, 32'h0);

        // First edge with reset released registers the inputs directly.
        step(4'b1111, 4'b1111, 1'b1, 1'b1);
        check("release", {27'd0, cout, sum}, 32'h1F);

        // Back-to-back vectors; outputs must hold the previous result until the edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = vecs[i].va; b = vecs[i].vb; carry = vecs[i].vc;
            #1;
            check($sformatf("hold_%0d", i), {27'd0, cout, sum},
                  (i == 0) ? 32'h1F : {27'd0, vecs[i-1].exp});
            @(posedge clk);
            #1;
            check($sformatf("vec_%0d", i), {27'd0, cout, sum}, {27'd0, vecs[i].exp});
        end

        // Synchronous reset dropped mid-stream.
        step(vecs[0].va, vecs[0].vb, vecs[0].vc, 1'b1);
        check("pre_rst", {27'd0, cout, sum}, {27'd0, vecs[0].exp});
        @(negedge clk);
        a = vecs[5].va; b = vecs[5].vb; carry = vecs[5].vc; rst_n = 1'b0;
        #1;
        check("rst_no_async", {27'd0, cout, sum}, {27'd0, vecs[0].exp});
        @(posedge clk);
        #1;
        check("rst_sync", {27'd0, cout, sum}, 32'h0);
        step(vecs[5].va, vecs[5].vb, vecs[5].vc, 1'b1);
        check("post_rst", {27'd0, cout, sum}, {27'd0, vecs[5].exp});

        // Exhaustive WIDTH=4 sweep.
        for (int i = 0; i < 512; i++) begin
            logic [8:0] idx;
            logic [4:0] exp;
            idx = i[8:0];
            exp = {1'b0, idx[7:4]} + {1'b0, idx[3:0]} + {4'd0, idx[8]};
            step(idx[7:4], idx[3:0], idx[8], 1'b1);
            check($sformatf("exh_%0d", i), {27'd0, cout, sum}, {27'd0, exp});
        end

        // Random WIDTH=16, BLK=4 run, including all-ones corners.
        for (int i = 0; i < 200; i++) begin
            logic [16:0] exp16;
            @(negedge clk);
            if (i == 0) begin
                a16 = 16'hFFFF; b16 = 16'h0000; carry16 = 1'b1;
            end else if (i == 1) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; carry16 = 1'b1;
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom); carry16 = 1'($urandom_range(0, 1));
            end
            exp16 = {1'b0, a16} + {1'b0, b16} + {16'd0, carry16};
            @(posedge clk);
            #1;
            check($sformatf("w16_%0d", i), {15'd0, cout16, sum16}, {15'd0, exp16});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
